spi_xfer_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `spi_master` instance between `NUM_REQ` independent requesters. It latches the winning requester's word and slave index, pulses the master's `start`, and waits for `finish` under a watchdog. It then returns the received word and a one-cycle done pulse to the winner, and steers the master's single `cs_n` onto one of `NUM_SS` slave-select lines. It sits between the `spi_master` and client logic such as sensor pollers and config writers.

---
 rtl/spi_xfer_arbiter.sv | 128 ++++++++++++
 tb/tb_spi_xfer_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter/sequencer sharing one spi_master between NUM_REQ requesters,
// with a finish watchdog and slave-select steering of the master's cs_n.
module spi_xfer_arbiter #(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned NUM_SS         = 2,
  parameter int unsigned SS_IDX_W       = (NUM_SS > 1) ? $clog2(NUM_SS) : 1,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned GAP_CYCLES     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ*SS_IDX_W-1:0]    req_ss,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output logic                           err,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           spi_start,
  output logic [DATA_WIDTH-1:0]          spi_data_in,
  input  logic                           spi_finish,
  input  logic [DATA_WIDTH-1:0]          spi_data_out,
  input  logic                           spi_cs_n,
  output logic [NUM_SS-1:0]              ss_n
);

  localparam int unsigned IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WD_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int unsigned WD_LAST  = TIMEOUT_CYCLES - 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_DONE, S_GAP} state_t;

  state_t              state;
  logic [IDX_W-1:0]    last;
  logic [IDX_W-1:0]    owner;
  logic [SS_IDX_W-1:0] sel;
  logic [WD_W-1:0]     wd;
  logic [GAP_W-1:0]    gap_cnt;
  logic [IDX_W-1:0]    pick_c;
  logic                found_c;
  int unsigned         cand_c;

  // Round-robin search starting just above the last granted index.
  always_comb begin
    pick_c  = last;
    found_c = 1'b0;
    cand_c  = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand_c = (32'(last) + i) % NUM_REQ;
      if (!found_c && req[IDX_W'(cand_c)]) begin
        pick_c  = IDX_W'(cand_c);
        found_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      last        <= IDX_W'(NUM_REQ - 1);
      owner       <= '0;
      sel         <= '0;
      wd          <= '0;
      gap_cnt     <= '0;
      grant       <= '0;
      done        <= '0;
      err         <= 1'b0;
      rdata       <= '0;
      spi_start   <= 1'b0;
      spi_data_in <= '0;
    end else begin
      spi_start <= 1'b0;
      done      <= '0;
      err       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            owner       <= pick_c;
            grant       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_c;
            spi_data_in <= req_data[pick_c*DATA_WIDTH +: DATA_WIDTH];
            sel         <= req_ss[pick_c*SS_IDX_W +: SS_IDX_W];
            spi_start   <= 1'b1;
            state       <= S_START;
          end
        end
        S_START: begin
          wd    <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          wd <= wd + WD_W'(1);
          // A finish on the final watchdog cycle still counts as success.
          if (spi_finish) begin
            rdata <= spi_data_out;
            done  <= grant;
            state <= S_DONE;
          end else if (wd == WD_W'(WD_LAST)) begin
            done  <= grant;
            err   <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          last    <= owner;
          grant   <= '0;
          gap_cnt <= '0;
          state   <= (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end
        S_GAP: begin
          gap_cnt <= gap_cnt + GAP_W'(1);
          if (gap_cnt == GAP_W'(GAP_LAST)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Only the latched slave sees the master's chip select; out-of-range selects none.
  always_comb begin
    for (int unsigned k = 0; k < NUM_SS; k++) begin
      ss_n[k] = spi_cs_n | (sel != SS_IDX_W'(k));
    end
  end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Self-checking bench for spi_xfer_arbiter with a behavioural spi_master model.
module tb_spi_xfer_arbiter;

  localparam int unsigned GAP = 2;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [23:0] req_data;
  logic [2:0]  req_ss;
  logic [2:0]  grant;
  logic [2:0]  done;
  logic        err;
  logic [7:0]  rdata;
  logic        spi_start;
  logic [7:0]  spi_data_in;
  logic        spi_finish;
  logic [7:0]  spi_data_out;
  logic        spi_cs_n;
  logic [1:0]  ss_n;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_done  = 0;
  int model_last;
  logic [7:0] model_rdata;

  int         m_fin_at = 1;
  logic [7:0] m_xor    = 8'h00;
  bit         m_late   = 1'b0;

  spi_xfer_arbiter #(
    .NUM_REQ(3), .DATA_WIDTH(8), .NUM_SS(2), .SS_IDX_W(1),
    .TIMEOUT_CYCLES(16), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_ss(req_ss),
    .grant(grant), .done(done), .err(err), .rdata(rdata),
    .spi_start(spi_start), .spi_data_in(spi_data_in), .spi_finish(spi_finish),
    .spi_data_out(spi_data_out), .spi_cs_n(spi_cs_n), .ss_n(ss_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference arbitration: first pending requester above the last winner.
  function automatic int rr(input logic [2:0] m, input int l);
    for (int i = 1; i <= 3; i++) begin
      int k;
      k = (l + i) % 3;
      if (((m >> k) & 3'd1) != 3'd0) return k;
    end
    return -1;
  endfunction

  // Master model: cs_n low for the transfer; finish on WAIT cycle m_fin_at (0 = never).
  initial begin
    int n;
    spi_finish   = 1'b0;
    spi_data_out = 8'h00;
    spi_cs_n     = 1'b1;
    forever begin
      @(negedge clk);
      if (spi_start) begin
        @(posedge clk); #1;
        spi_cs_n = 1'b0;
        if (m_fin_at == 0) begin
          n = 0;
          while (!(|done) && !rst && n < 60) begin
            @(posedge clk); #1;
            n++;
          end
          spi_cs_n = 1'b1;
          if (m_late && !rst) begin
            spi_data_out = 8'h77;
            spi_finish   = 1'b1;
            @(posedge clk); #1;
            spi_finish   = 1'b0;
          end
        end else begin
          repeat (m_fin_at - 1) @(posedge clk);
          if (m_fin_at > 1) #1;
          spi_data_out = spi_data_in ^ m_xor;
          spi_finish   = 1'b1;
          @(posedge clk); #1;
          spi_finish   = 1'b0;
          spi_cs_n     = 1'b1;
        end
      end
    end
  end

  // One complete transfer for requester w, checked end to end.
  task automatic do_xfer(input int w, input int fin_at, input logic [7:0] xr,
                         input bit chg, input bit gap_chk, input logic [2:0] next_req);
    int n;
    int t0;
    logic [7:0] d;
    logic [1:0] exp_ss;
    logic [2:0] g;
    m_fin_at = fin_at;
    m_xor    = xr;
    d        = req_data[w*8 +: 8];
    exp_ss   = req_ss[w] ? 2'b01 : 2'b10;
    g        = 3'b001 << w;
    n = 0;
    @(negedge clk);
    while (!spi_start && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", 32'(spi_start), 32'd1);
    if (!spi_start) return;
    t0 = cyc;
    check("grant", 32'(grant), 32'(g));
    check("mosi_word", 32'(spi_data_in), 32'(d));
    if (gap_chk) check("gap_spacing", 32'(t0 - t_done), 32'(GAP + 2));
    @(negedge clk);
    check("start_1cyc", 32'(spi_start), 32'd0);
    check("ss_n", 32'(ss_n), 32'(exp_ss));
    if (chg) begin
      req_data[w*8 +: 8] = 8'h3C;
      req_ss[w]          = 1'b0;
      @(negedge clk);
      check("ss_n_hold", 32'(ss_n), 32'(exp_ss));
      check("mosi_hold", 32'(spi_data_in), 32'(d));
    end
    n = 0;
    while (!(|done) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (fin_at != 0) model_rdata = d ^ xr;
    check("done", 32'(done), 32'(g));
    check("err", 32'(err), (fin_at == 0) ? 32'd1 : 32'd0);
    check("rdata", 32'(rdata), 32'(model_rdata));
    check("latency", 32'(cyc - t0), (fin_at == 0) ? 32'd17 : 32'(fin_at + 1));
    check("grant_at_done", 32'(grant), 32'(g));
    model_last = w;
    t_done     = cyc;
    req        = next_req;
    req_data[w*8 +: 8] = 8'($urandom);
    req_ss[w]          = 1'($urandom);
    @(negedge clk);
    check("done_clr", 32'(done), 32'd0);
    check("err_clr", 32'(err), 32'd0);
    check("grant_clr", 32'(grant), 32'd0);
    check("ss_n_idle", 32'(ss_n), 32'd3);
  endtask

  initial begin
    int w;
    int n;
    int fin;
    rst      = 1'b1;
    req      = 3'b000;
    req_data = 24'h0;
    req_ss   = 3'b000;
    model_last  = 2;
    model_rdata = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_start", 32'(spi_start), 32'd0);
    check("rst_mosi", 32'(spi_data_in), 32'd0);
    check("rst_ss_n", 32'(ss_n), 32'd3);
    rst = 1'b0;
    @(negedge clk);

    // Single request, loopback
    req_data[15:8] = 8'hA5;
    req_ss[1]      = 1'b1;
    req            = 3'b010;
    do_xfer(rr(req, model_last), 5, 8'h00, 1'b0, 1'b0, 3'b000);

    // Timeout with a late finish that must be ignored
    req_data[7:0] = 8'($urandom);
    req_ss[0]     = 1'b0;
    m_late        = 1'b1;
    req           = 3'b001;
    do_xfer(rr(req, model_last), 0, 8'h00, 1'b0, 1'b0, 3'b000);
    m_late = 1'b0;
    repeat (4) @(negedge clk);
    check("late_fin_rdata", 32'(rdata), 32'hA5);
    check("late_fin_done", 32'(done), 32'd0);

    // Finish on the last watchdog cycle
    req_data[23:16] = 8'($urandom);
    req_ss[2]       = 1'b1;
    req             = 3'b100;
    do_xfer(rr(req, model_last), 16, 8'($urandom), 1'b0, 1'b0, 3'b000);

    // Owner changes its inputs mid-transfer
    req_data[15:8] = 8'($urandom);
    req_ss[1]      = 1'b1;
    req            = 3'b010;
    do_xfer(rr(req, model_last), 10, 8'h5A, 1'b1, 1'b0, 3'b000);

    // All requesting, re-requesting immediately
    req = 3'b111;
    for (int t = 0; t < 4; t++) begin
      w = rr(req, model_last);
      do_xfer(w, int'($urandom_range(1, 12)), 8'($urandom), 1'b0, (t > 0), 3'b111);
    end

    // Random request masks, occasional timeouts
    for (int t = 0; t < 10; t++) begin
      w   = rr(req, model_last);
      fin = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, 16));
      do_xfer(w, fin, 8'($urandom), 1'b0, 1'b1,
              (t == 9) ? 3'b000 : 3'($urandom_range(1, 7)));
    end
    repeat (3) @(negedge clk);

    // Reset in the middle of WAIT
    m_fin_at = 0;
    req      = 3'b001;
    n = 0;
    @(negedge clk);
    while (!spi_start && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("mr_start_seen", 32'(spi_start), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mr_grant", 32'(grant), 32'd0);
    check("mr_done", 32'(done), 32'd0);
    check("mr_start", 32'(spi_start), 32'd0);
    check("mr_rdata", 32'(rdata), 32'd0);
    repeat (2) @(negedge clk);
    rst         = 1'b0;
    model_last  = 2;
    model_rdata = 8'h00;
    req         = 3'b100;
    do_xfer(rr(req, model_last), 4, 8'($urandom), 1'b0, 1'b0, 3'b011);
    do_xfer(rr(req, model_last), 3, 8'($urandom), 1'b0, 1'b1, 3'b010);
    do_xfer(rr(req, model_last), 6, 8'($urandom), 1'b0, 1'b1, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
